// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster coordinates, renderer colour return and VGA pin bundle
interface vga_timing_gen_if;
  logic [10:0] curr_x;
  logic [10:0] curr_y;
  logic [3:0]  draw_r;
  logic [3:0]  draw_g;
  logic [3:0]  draw_b;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        hsync;
  logic        vsync;
  logic        active;
  logic        vblank_start;
  logic        game_tick;
  modport master (
    output curr_x, curr_y, vga_r, vga_g, vga_b, hsync, vsync, active, vblank_start, game_tick,
    input  draw_r, draw_g, draw_b
  );
  modport slave (
    input  curr_x, curr_y, vga_r, vga_g, vga_b, hsync, vsync, active, vblank_start, game_tick,
    output draw_r, draw_g, draw_b
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster scan counters, pipeline-aligned sync/RGB outputs, vblank strobe and game tick
module vga_timing_gen #(
  parameter int H_ACTIVE    = 1440,
  parameter int H_FP        = 80,
  parameter int H_SYNC      = 152,
  parameter int H_BP        = 232,
  parameter int V_ACTIVE    = 900,
  parameter int V_FP        = 1,
  parameter int V_SYNC      = 3,
  parameter int V_BP        = 28,
  parameter bit H_SYNC_POL  = 1'b0,
  parameter bit V_SYNC_POL  = 1'b1,
  parameter int PIPE_DELAY  = 2,
  parameter int TICK_FRAMES = 8
) (
  input logic            clk,
  input logic            rst,
  vga_timing_gen_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FW = $clog2(TICK_FRAMES + 1);
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS  = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [FW-1:0] FC_LAST = FW'(TICK_FRAMES - 1);
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic [FW-1:0] fc;
  logic [PIPE_DELAY-1:0] d_act;
  logic [PIPE_DELAY-1:0] d_hs;
  logic [PIPE_DELAY-1:0] d_vs;
  logic h_wrap;
  logic raw_act;
  logic raw_hs;
  logic raw_vs;
  logic vbs;
  assign bus.curr_x       = hcount;
  assign bus.curr_y       = vcount;
  assign bus.active       = raw_act;
  assign bus.vblank_start = vbs;
  assign bus.game_tick    = vbs && (fc == FC_LAST);
  // decode position-dependent flags straight from the counter registers
  always_comb begin
    h_wrap  = hcount == H_LAST;
    raw_act = (hcount < H_VIS) && (vcount < V_VIS);
    raw_hs  = (hcount >= HS_BEG) && (hcount < HS_END);
    raw_vs  = (vcount >= VS_BEG) && (vcount < VS_END);
    vbs     = (hcount == '0) && (vcount == V_VIS);
  end
  // raster counters: vcount steps only when the line wraps
  always_ff @(posedge clk) begin
    if (!rst) begin
      hcount <= '0;
      vcount <= '0;
    end else begin
      hcount <= h_wrap ? '0 : hcount + 11'd1;
      if (h_wrap) vcount <= (vcount == V_LAST) ? '0 : vcount + 11'd1;
    end
  end
  // frame counter paces game_tick and restarts on each tick
  always_ff @(posedge clk) begin
    if (!rst) fc <= '0;
    else if (vbs) fc <= (fc == FC_LAST) ? '0 : fc + FW'(1);
  end
  // delay raw flags to meet the renderer's colour, then register the VGA pins
  always_ff @(posedge clk) begin
    if (!rst) begin
      d_act     <= '0;
      d_hs      <= '0;
      d_vs      <= '0;
      bus.vga_r <= '0;
      bus.vga_g <= '0;
      bus.vga_b <= '0;
      bus.hsync <= ~H_SYNC_POL;
      bus.vsync <= ~V_SYNC_POL;
    end else begin
      d_act     <= PIPE_DELAY'({d_act, raw_act});
      d_hs      <= PIPE_DELAY'({d_hs, raw_hs});
      d_vs      <= PIPE_DELAY'({d_vs, raw_vs});
      bus.vga_r <= d_act[PIPE_DELAY-1] ? bus.draw_r : '0;
      bus.vga_g <= d_act[PIPE_DELAY-1] ? bus.draw_g : '0;
      bus.vga_b <= d_act[PIPE_DELAY-1] ? bus.draw_b : '0;
      bus.hsync <= d_hs[PIPE_DELAY-1] ? H_SYNC_POL : ~H_SYNC_POL;
      bus.vsync <= d_vs[PIPE_DELAY-1] ? V_SYNC_POL : ~V_SYNC_POL;
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for small-geometry timing plus a default-geometry hsync check
module tb_vga_timing_gen;
  localparam int HA = 8, HF = 2, HS = 3, HB = 3, HT = HA + HF + HS + HB;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1, VT = VA + VF + VS + VB;
  localparam int PD = 2, TF = 3, FR = HT * VT;
  localparam int DHT = 1904;
  typedef struct {
    int x, y, act, vbs, gt, r, g, b, hs, vs;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  logic rst2;
  int checks = 0;
  int errors = 0;
  int s = 0;
  bit seen = 1'b0;
  exp_t q[$];
  exp_t m;
  vga_timing_gen_if bus();
  vga_timing_gen_if bus2();
  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b1), .PIPE_DELAY(PD), .TICK_FRAMES(TF)
  ) dut (.clk(clk), .rst(rst), .bus(bus));
  vga_timing_gen dut_def (.clk(clk), .rst(rst2), .bus(bus2));
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask
  function automatic int xof(input int p);
    return p % HT;
  endfunction
  function automatic int yof(input int p);
    return (p / HT) % VT;
  endfunction
  function automatic bit vis(input int p);
    return p >= 0 && xof(p) < HA && yof(p) < VA;
  endfunction
  function automatic bit hpulse(input int p);
    return p >= 0 && xof(p) >= HA + HF && xof(p) < HA + HF + HS;
  endfunction
  function automatic bit vpulse(input int p);
    return p >= 0 && yof(p) >= VA + VF && yof(p) < VA + VF + VS;
  endfunction
  task automatic step(input bit r);
    exp_t e;
    int dr, dg, db, nv;
    @(negedge clk);
    dr = $urandom_range(15);
    dg = $urandom_range(15);
    db = $urandom_range(15);
    rst = r;
    bus.draw_r = 4'(dr);
    bus.draw_g = 4'(dg);
    bus.draw_b = 4'(db);
    if (!r) begin
      s = 0;
      seen = 1'b1;
      e.r = 0; e.g = 0; e.b = 0; e.hs = 1; e.vs = 0;
    end else begin
      e.r  = vis(s - PD) ? dr : 0;
      e.g  = vis(s - PD) ? dg : 0;
      e.b  = vis(s - PD) ? db : 0;
      e.hs = hpulse(s - PD) ? 0 : 1;
      e.vs = vpulse(s - PD) ? 1 : 0;
      s++;
    end
    e.x   = xof(s);
    e.y   = yof(s);
    e.act = vis(s) ? 1 : 0;
    e.vbs = (xof(s) == 0 && yof(s) == VA) ? 1 : 0;
    nv    = (s >= VA * HT) ? (s - VA * HT) / FR + 1 : 0;
    e.gt  = (e.vbs == 1 && nv % TF == 0) ? 1 : 0;
    if (seen) q.push_back(e);
  endtask
  task automatic stim();
    repeat (3) step(1'b0);
    repeat (1300) step(1'b1);
    while (s % FR != 2 * HT + 6) step(1'b1);
    step(1'b0);
    repeat (500) step(1'b1);
    repeat (3000) step($urandom_range(299) != 0);
  endtask
  task automatic dflt();
    int s2, p;
    @(negedge clk) rst2 = 1'b0;
    @(negedge clk) rst2 = 1'b1;
    s2 = 0;
    repeat (3 * DHT + 8) begin
      @(posedge clk);
      s2++;
      #2;
      p = s2 - 3;
      chk("def_curr_x", int'(bus2.curr_x), s2 % DHT);
      chk("def_hsync", int'(bus2.hsync), (p >= 0 && p % DHT >= 1520 && p % DHT < 1672) ? 0 : 1);
      chk("def_vsync", int'(bus2.vsync), 0);
    end
  endtask
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        m = q.pop_front();
        chk("curr_x", int'(bus.curr_x), m.x);
        chk("curr_y", int'(bus.curr_y), m.y);
        chk("active", int'(bus.active), m.act);
        chk("vblank_start", int'(bus.vblank_start), m.vbs);
        chk("game_tick", int'(bus.game_tick), m.gt);
        chk("vga_r", int'(bus.vga_r), m.r);
        chk("vga_g", int'(bus.vga_g), m.g);
        chk("vga_b", int'(bus.vga_b), m.b);
        chk("hsync", int'(bus.hsync), m.hs);
        chk("vsync", int'(bus.vsync), m.vs);
      end
    end
  end
  initial begin
    rst = 1'b0;
    rst2 = 1'b0;
    bus.draw_r = '0;
    bus.draw_g = '0;
    bus.draw_b = '0;
    bus2.draw_r = '0;
    bus2.draw_g = '0;
    bus2.draw_b = '0;
    fork
      stim();
      dflt();
    join
    repeat (3) @(posedge clk);
    #3;
    chk("scoreboard_drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Display-side timing source for the snake renderer.
- Generates the raster scan (curr_x, curr_y) that the pixel renderer consumes.
- Captures the renderer's draw_r/g/b and drives the VGA connector: blanked RGB, hsync and vsync, all delay-matched to the renderer pipeline.
- Also provides the per-frame vblank strobe and the divided game_tick that paces snake movement.

Parameters:
- H_ACTIVE, 1440, visible pixels per line
- H_FP, 80, horizontal front porch (clocks)
- H_SYNC, 152, hsync pulse width
- H_BP, 232, horizontal back porch
- V_ACTIVE, 900, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 3, vsync pulse width
- V_BP, 28, vertical back porch
- H_SYNC_POL, 0, hsync asserted level (0 = active-low)
- V_SYNC_POL, 1, vsync asserted level
- PIPE_DELAY, 2, cycles from curr_x/curr_y to valid draw_*; minimum 1
- TICK_FRAMES, 8, frames per game_tick; minimum 1

Ports:
- clk  in  1  pixel clock (106.47 MHz for defaults)
- rst  in  1  synchronous, active-low reset
- curr_x  out  11  horizontal counter
- curr_y  out  11  vertical counter
- draw_r  in  4  renderer red, valid PIPE_DELAY cycles after the matching curr_x/curr_y
- draw_g  in  4  renderer green
- draw_b  in  4  renderer blue
- vga_r  out  4  red to DAC
- vga_g  out  4  green to DAC
- vga_b  out  4  blue to DAC
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- active  out  1  current curr_x/curr_y inside the visible area (undelayed)
- vblank_start  out  1  one-cycle strobe at start of vertical blanking
- game_tick  out  1  one-cycle strobe every TICK_FRAMES frames

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1904); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (932).
- hcount: register, 0..H_TOTAL-1; wraps to 0.
- vcount: register; increments only when hcount wraps. vcount wraps to 0 when hcount wraps at vcount = V_TOTAL-1.
- curr_x = hcount and curr_y = vcount, driven directly from the registers, including during blanking (no clamping).
- active = (hcount < H_ACTIVE) && (vcount < V_ACTIVE).
- Raw hsync is asserted while H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC. Raw vsync uses the same rule on vcount with the V_* parameters.
- Alignment delay line: raw active, hsync and vsync pass through a PIPE_DELAY-stage shift register.
- Output registers (cycle n = cycle in which a given curr_x/curr_y is presented):
  - At the end of cycle n+PIPE_DELAY: vga_rgb <= delayed_active ? draw_* : 0; hsync/vsync <= delayed value mapped to its polarity.
  - The pixel issued in cycle n therefore appears on the VGA pins in cycle n+PIPE_DELAY+1, with its own sync levels.
- RGB is forced to 0 whenever delayed_active = 0, regardless of draw_*.
- vblank_start = (hcount == 0) && (vcount == V_ACTIVE); decoded from the counter registers, undelayed.
- Frame counter fc:
  - Counts 0..TICK_FRAMES-1 and advances on each vblank_start.
  - game_tick = vblank_start && (fc == TICK_FRAMES-1); fc returns to 0 on that strobe.
  - The first game_tick after reset is on the TICK_FRAMES-th vblank_start.
- Reset (rst = 0 at a clock edge):
  - hcount, vcount and fc go to 0; delay line is cleared to inactive/deasserted.
  - vga_rgb = 0; hsync = !H_SYNC_POL; vsync = !V_SYNC_POL.
  - active = 1 while held (counters sit at 0,0); vblank_start = 0; game_tick = 0.
- Reset mid-frame: takes effect at the next edge. The scan restarts at (0,0) with no partial sync pulse emitted afterward.
- Each counter has exactly one driver. No combinational path from draw_* to any output.

Test Plan:
- Use small parameters: H 8/2/3/3 (H_TOTAL 16), V 4/1/2/1 (V_TOTAL 8), PIPE_DELAY 2, TICK_FRAMES 3. Release reset and run 128 cycles → curr_x cycles 0..15; curr_y steps 0..7 on each x wrap and returns to 0 at cycle 128; active high exactly for x<8 && y<4 (32 of 128 cycles).
- Same setup, hsync check → hsync low (H_SYNC_POL 0) exactly when curr_x was 10..12, observed 3 cycles later; vsync high for lines 5..6, also lagging 3 cycles; each pulse 3 clocks / 2 lines wide.
- Renderer model returns draw_r = curr_x[3:0] delayed 2 cycles and draw_g = draw_b = 4'hF → vga_r shows 0..7 in order, lagging curr_x by 3 cycles; vga_rgb = 0 for every blanked pixel even though draw_g = draw_b = F.
- Run 10 frames → vblank_start pulses once per frame, at (x=0, y=4); game_tick pulses at frames 3, 6, 9 only, each one cycle wide.
- Assert rst low for 1 cycle at (x=6, y=2) → next cycle curr_x = curr_y = 0, vga_rgb = 0, hsync = 1, vsync = 0; the next game_tick comes 3 full vblank_starts later.
- Default parameters, one full frame → 1,774,528 cycles between vblank_start pulses; hsync low for cycles 1520..1671 of each line.
